// File: rtl/uart_debug_master.sv
// uart_debug_master: host-driven bus initiator over an 8N1 serial link.
// 'W' A0..A3 D0..D3 writes a word and answers 'K'; 'R' A0..A3 answers R0..R3.
module uart_debug_master #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP
  } state_t;

  state_t        state, state_nx;
  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_active;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_done, rx_err;
  logic          cmd_ok;
  logic [1:0]    byte_cnt;
  logic          is_wr;
  logic [31:0]   addr_q, wdata_q;
  logic          tx_active;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [2:0]    tx_left;
  logic [31:0]   tx_buf;
  logic          tx_load, tx_done;

  // Receiver: synchronize, find the start edge, sample bit centres.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_done   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
      if (!rx_active) begin
        if (rx_s3 && !rx_s2) begin
          rx_active <= 1'b1;
          rx_cnt    <= '0;
          rx_bit    <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          if (rx_s2) rx_active <= 1'b0;
          else       rx_bit    <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt == LAST) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_active <= 1'b0;
          rx_done   <= rx_s2;
          rx_err    <= !rx_s2;
        end else begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  assign cmd_ok = rx_done && (rx_shift == 8'h57 || rx_shift == 8'h52);

  // Parser state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_CMD;
    else       state <= state_nx;
  end

  // Parser next state; bytes arriving in BUS/RESP fall through unused.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_CMD:  if (cmd_ok) state_nx = S_ADDR;
      S_ADDR: begin
        if (rx_err)
          state_nx = S_CMD;
        else if (rx_done && byte_cnt == 2'd3)
          state_nx = is_wr ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_err)
          state_nx = S_CMD;
        else if (rx_done && byte_cnt == 2'd3)
          state_nx = S_BUS;
      end
      S_BUS:  if (mem_ready) state_nx = S_RESP;
      S_RESP: if (tx_done) state_nx = S_CMD;
      default: state_nx = S_CMD;
    endcase
  end

  // Command fields shift in little-endian.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      is_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_CMD: if (cmd_ok) begin
          is_wr    <= (rx_shift == 8'h57);
          byte_cnt <= '0;
        end
        S_ADDR: if (rx_done) begin
          addr_q   <= {rx_shift, addr_q[31:8]};
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_DATA: if (rx_done) begin
          wdata_q  <= {rx_shift, wdata_q[31:8]};
          byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_valid = (state == S_BUS);
  assign mem_instr = 1'b0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = (mem_valid && is_wr) ? 4'hF : 4'h0;

  assign tx_load = mem_valid && mem_ready;
  assign tx_done = tx_active && tx_cnt == LAST &&
                   tx_bit == 4'd9 && tx_left == 3'd1;

  // Transmitter: start bit goes out the cycle after mem_ready,
  // bytes chained with no idle gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uart_tx   <= 1'b1;
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_left   <= '0;
      tx_buf    <= '0;
    end else if (tx_load) begin
      uart_tx   <= 1'b0;
      tx_active <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_left   <= is_wr ? 3'd1 : 3'd4;
      tx_buf    <= is_wr ? 32'h0000_004B : mem_rdata;
    end else if (tx_active) begin
      if (tx_cnt != LAST) begin
        tx_cnt <= tx_cnt + CW'(1);
      end else begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          if (tx_left == 3'd1) begin
            tx_active <= 1'b0;
            uart_tx   <= 1'b1;
          end else begin
            tx_left <= tx_left - 3'd1;
            tx_buf  <= tx_buf >> 8;
            tx_bit  <= '0;
            uart_tx <= 1'b0;
          end
        end else begin
          tx_bit  <= tx_bit + 4'd1;
          uart_tx <= (tx_bit == 4'd8) ? 1'b1 : tx_buf[tx_bit[2:0]];
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_debug_master.sv
// tb_uart_debug_master: serial host model, bus memory model and
// scoreboards for uart_debug_master at 4 clocks per bit.
module tb_uart_debug_master;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    int          wait_cyc;
  } bus_t;

  bus_t       bus_q[$];
  logic [7:0] tx_q[$];
  bus_t       cur;
  int         checks = 0;
  int         failures = 0;
  int         vcyc = 0;
  int         bus_cnt = 0;
  int         rst_gen = 0;
  int         mon_g;
  logic [7:0] mon_b;
  logic       mon_st, mon_sp;

  uart_debug_master #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clk), .reset(rst),
    .uart_rx(uart_rx), .uart_tx(uart_tx),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus responder: pops one expected access per request.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = $urandom();
    if (rst) begin
      vcyc = 0;
    end else if (mem_valid) begin
      if (vcyc == 0) begin
        chk("bus_pending", 32'(bus_q.size() > 0), 1);
        if (bus_q.size() > 0) cur = bus_q.pop_front();
        else cur = '{addr: 0, wdata: 0, rdata: 0, wstrb: 0, wait_cyc: 0};
        chk("bus_instr", mem_instr, 0);
        chk("bus_wdata",
            (cur.wstrb == 4'hF) ? mem_wdata : cur.wdata, cur.wdata);
      end
      chk("bus_addr", mem_addr, cur.addr);
      chk("bus_wstrb", mem_wstrb, cur.wstrb);
      if (vcyc == cur.wait_cyc) begin
        mem_ready = 1'b1;
        mem_rdata = cur.rdata;
      end
      vcyc++;
    end else if (vcyc != 0) begin
      chk("valid_len", vcyc, cur.wait_cyc + 1);
      vcyc = 0;
      bus_cnt++;
    end
  end

  // Serial decoder on uart_tx; bytes cut by reset are not scored.
  always begin
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      mon_g = rst_gen;
      repeat (2) @(negedge clk);
      mon_st = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      mon_sp = uart_tx;
      if (mon_g == rst_gen) begin
        chk("tx_start", mon_st, 0);
        chk("tx_stop", mon_sp, 1);
        chk("tx_pending", 32'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) chk("tx_byte", mon_b, tx_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    if (!stop) repeat (8) @(negedge clk);
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d,
                            input int w);
    bus_q.push_back('{addr: a, wdata: d, rdata: 0, wstrb: 4'hF,
                      wait_cyc: w});
    tx_q.push_back(8'h4B);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d,
                            input int w);
    push_write(a, d, w);
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic send_read(input logic [31:0] a, input logic [31:0] r,
                           input int w);
    bus_q.push_back('{addr: a, wdata: 0, rdata: r, wstrb: 4'h0,
                      wait_cyc: w});
    for (int i = 0; i < 4; i++) tx_q.push_back(r[8*i +: 8]);
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (bus_q.size() == 0 && tx_q.size() == 0 &&
          !mem_valid && uart_tx === 1'b1) done = 1'b1;
    end
    chk(tag, done, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_sig(input string tag, input logic want_valid);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (want_valid ? (mem_valid === 1'b1) : (uart_tx === 1'b0))
        done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  int n0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_valid", mem_valid, 0);
    chk("rst_instr", mem_instr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    n0 = bus_cnt;
    send_write(32'h8000_1000, 32'hDEAD_BEEF, 2);
    wait_idle("write_done");
    chk("write_count", bus_cnt - n0, 1);

    n0 = bus_cnt;
    send_read(32'h8000_0004, 32'h1234_5678, 5);
    wait_idle("read_done");
    chk("read_count", bus_cnt - n0, 1);

    n0 = bus_cnt;
    send_read(32'h0000_0010, 32'hCAFE_F00D, 0);
    wait_idle("zw_read1");
    send_read(32'h0000_0014, 32'h0BAD_1DEA, 0);
    wait_idle("zw_read2");
    chk("zw_count", bus_cnt - n0, 2);

    n0 = bus_cnt;
    send_byte(8'hAA, 1'b1);
    send_write(32'h0000_0100, 32'hA5A5_0001, 1);
    wait_idle("unknown_cmd");
    chk("unknown_count", bus_cnt - n0, 1);

    n0 = bus_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h33, 1'b0);
    send_read(32'h2000_0003, 32'h5555_AAAA, 1);
    wait_idle("frame_err");
    chk("frame_count", bus_cnt - n0, 1);

    n0 = bus_cnt;
    push_write(32'h4433_2211, 32'h8877_6655, 0);
    send_byte(8'h57, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    wait_idle("glitch");
    chk("glitch_count", bus_cnt - n0, 1);

    send_read(32'h3000_0000, 32'hFFFF_FFFF, 100000);
    wait_sig("rst_bus_wait", 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rst_gen++;
    #1;
    chk("rst_bus_valid", mem_valid, 0);
    chk("rst_bus_tx", uart_tx, 1);
    chk("rst_bus_addr", mem_addr, 0);
    tx_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n0 = bus_cnt;
    send_write(32'h0000_0200, 32'h0102_0304, 0);
    wait_idle("after_rst_bus");
    chk("after_rst_bus_count", bus_cnt - n0, 1);

    send_read(32'h0000_0300, 32'h9876_5432, 0);
    wait_sig("rst_tx_wait", 1'b0);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    rst_gen++;
    #1;
    chk("rst_tx_line", uart_tx, 1);
    chk("rst_tx_valid", mem_valid, 0);
    tx_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    n0 = bus_cnt;
    send_read(32'h0000_0304, 32'h1357_9BDF, 3);
    wait_idle("after_rst_tx");
    chk("after_rst_tx_count", bus_cnt - n0, 1);

    n0 = bus_cnt;
    send_read(32'h0000_0400, 32'h2468_ACE0, 60);
    send_byte(8'h57, 1'b1);
    send_byte(8'h52, 1'b1);
    send_byte(8'h57, 1'b1);
    wait_idle("discard");
    send_write(32'h0000_0404, 32'hFEED_FACE, 0);
    wait_idle("discard_next");
    chk("discard_count", bus_cnt - n0, 2);

    chk("bus_q_empty", bus_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
